// File: rtl/lab4_cpu_dct_pkg.sv
// ============================================================================
// lab4_cpu_dct_pkg : shared widths, FSM encoding and atom-insert helper
//                    for the Nios II OCI DCT packer.
// Revision 1.0
// ============================================================================
`default_nettype none

package lab4_cpu_dct_pkg;

  localparam int DCT_ATOMS  = 15;
  localparam int DCT_ATOM_W = 2;
  localparam int DCT_WORD_W = 30;
  localparam int DCT_CNT_W  = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ENDED = 2'd2
  } dct_state_t;

  // Returns word with atom written at slot pos (atom k lives at bits [2k+1:2k]).
  function automatic logic [DCT_WORD_W-1:0] dct_insert_atom(
    input logic [DCT_WORD_W-1:0] word,
    input logic [DCT_CNT_W-1:0]  pos,
    input logic [DCT_ATOM_W-1:0] atom
  );
    logic [DCT_WORD_W-1:0] result;
    result = word;
    for (int k = 0; k < DCT_ATOMS; k++) begin
      if (pos == DCT_CNT_W'(k)) begin
        result[k*DCT_ATOM_W +: DCT_ATOM_W] = atom;
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab4_cpu_nios2_oci_dct_slot.sv
// ============================================================================
// lab4_cpu_nios2_oci_dct_slot : valid/ready output holding register for packed
//                               DCT words; reports when the slot frees.
// Revision 1.0
// ============================================================================
`default_nettype none

module lab4_cpu_nios2_oci_dct_slot
  import lab4_cpu_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DCT_WORD_W-1:0] load_word,
  input  logic [DCT_CNT_W-1:0]  load_cnt,
  input  logic                  word_ready,
  output logic                  frees,
  output logic                  word_valid,
  output logic [DCT_WORD_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count
);

  logic                  valid_q, valid_d;
  logic [DCT_WORD_W-1:0] buf_q, buf_d;
  logic [DCT_CNT_W-1:0]  cnt_q, cnt_d;

  // The caller only raises load in a cycle where frees is high.
  always_comb begin
    frees   = !valid_q || word_ready;
    valid_d = valid_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    if (load) begin
      valid_d = 1'b1;
      buf_d   = load_word;
      cnt_d   = load_cnt;
    end else if (frees) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_valid = valid_q;
  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/lab4_cpu_nios2_oci_dct_packer.sv
// ============================================================================
// lab4_cpu_nios2_oci_dct_packer : packs 2-bit trace atoms into 15-atom words,
//   flushes on end-of-test. Optional drop counter: LAB4_CPU_DCT_DROP_CNT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module lab4_cpu_nios2_oci_dct_packer
  import lab4_cpu_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  atom_valid,
  input  logic [DCT_ATOM_W-1:0] atom,
  input  logic                  test_ending,
  input  logic                  word_ready,
  output logic                  word_valid,
  output logic [DCT_WORD_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
`ifdef LAB4_CPU_DCT_DROP_CNT_EN
  output logic [15:0]           dct_drop_count,
`endif
  output logic                  test_has_ended
);

  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(DCT_ATOMS);

  dct_state_t            state_q, state_d;
  logic [DCT_WORD_W-1:0] fill_buf_q, fill_buf_d;
  logic [DCT_CNT_W-1:0]  fill_cnt_q, fill_cnt_d;

  logic                  slot_load;
  logic [DCT_WORD_W-1:0] slot_word;
  logic [DCT_CNT_W-1:0]  slot_cnt;
  logic                  slot_frees;

  logic [DCT_WORD_W-1:0] packed_word;
  logic [DCT_CNT_W-1:0]  packed_cnt;

  always_comb begin
    state_d     = state_q;
    fill_buf_d  = fill_buf_q;
    fill_cnt_d  = fill_cnt_q;
    slot_load   = 1'b0;
    slot_word   = fill_buf_q;
    slot_cnt    = fill_cnt_q;
    packed_word = dct_insert_atom(fill_buf_q, fill_cnt_q, atom);
    packed_cnt  = fill_cnt_q + 1'b1;

    case (state_q)
      RUN: begin
        if (fill_cnt_q == FULL_CNT) begin
          // Full fill drains into the slot; a same-cycle atom starts the next word.
          if (slot_frees) begin
            slot_load  = 1'b1;
            fill_buf_d = atom_valid ? DCT_WORD_W'(atom) : '0;
            fill_cnt_d = atom_valid ? DCT_CNT_W'(1) : '0;
          end
        end else if (atom_valid) begin
          if (packed_cnt == FULL_CNT && slot_frees) begin
            slot_load  = 1'b1;
            slot_word  = packed_word;
            slot_cnt   = FULL_CNT;
            fill_buf_d = '0;
            fill_cnt_d = '0;
          end else begin
            fill_buf_d = packed_word;
            fill_cnt_d = packed_cnt;
          end
        end
        if (test_ending) begin
          // Nothing left to drain: skip FLUSH so the ended flag rises next edge.
          if (fill_cnt_d == '0 && !slot_load && !word_valid) begin
            state_d = ENDED;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (fill_cnt_q != '0) begin
          if (slot_frees) begin
            slot_load  = 1'b1;
            fill_buf_d = '0;
            fill_cnt_d = '0;
          end
        end else if (!word_valid) begin
          state_d = ENDED;
        end
      end
      ENDED: begin
        state_d = ENDED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      fill_buf_q <= '0;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_buf_q <= fill_buf_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  lab4_cpu_nios2_oci_dct_slot u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (slot_load),
    .load_word  (slot_word),
    .load_cnt   (slot_cnt),
    .word_ready (word_ready),
    .frees      (slot_frees),
    .word_valid (word_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count)
  );

  assign test_has_ended = (state_q == ENDED);

`ifdef LAB4_CPU_DCT_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Only RUN can drop: FLUSH and ENDED ignore atoms outright.
  always_comb begin
    drop       = (state_q == RUN) && atom_valid && (fill_cnt_q == FULL_CNT) && !slot_frees;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dct_drop_count = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lab4_cpu_nios2_oci_dct_packer.sv
// ============================================================================
// tb_lab4_cpu_nios2_oci_dct_packer : directed self-checking bench for the DCT packer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lab4_cpu_nios2_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        test_ending;
  logic        word_ready;
  logic        word_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
`ifdef LAB4_CPU_DCT_DROP_CNT_EN
  logic [15:0] dct_drop_count;
`endif

  int checks;
  int failures;

  lab4_cpu_nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .test_ending    (test_ending),
    .word_ready     (word_ready),
    .word_valid     (word_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
`ifdef LAB4_CPU_DCT_DROP_CNT_EN
    .dct_drop_count (dct_drop_count),
`endif
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    atom_valid  = 1'b0;
    atom        = 2'b00;
    test_ending = 1'b0;
    word_ready  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #2;
  endtask

  task automatic send_atoms(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) begin
      atom_valid = 1'b1;
      atom       = a;
      step();
    end
    atom_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // ---- reset state
    apply_reset();
    check_eq("rst_valid", 32'(word_valid), 32'd0);
    check_eq("rst_buffer", 32'(dct_buffer), 32'd0);
    check_eq("rst_count", 32'(dct_count), 32'd0);
    check_eq("rst_ended", 32'(test_has_ended), 32'd0);

    // ---- 15 atoms 0,1,2,3,... with ready: word one edge after 15th atom
    word_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      atom_valid = 1'b1;
      atom       = 2'(k % 4);
      step();
      if (k == 13) check_eq("seq_not_yet", 32'(word_valid), 32'd0);
    end
    atom_valid = 1'b0;
    check_eq("seq_valid", 32'(word_valid), 32'd1);
    check_eq("seq_buffer", 32'(dct_buffer), 32'h24E4E4E4);
    check_eq("seq_count", 32'(dct_count), 32'd15);
    step();
    check_eq("seq_accepted", 32'(word_valid), 32'd0);

    // ---- 45 atoms, no ready: first word held, second fills, third dropped
    apply_reset();
    send_atoms(15, 2'b01);
    check_eq("bp_first_valid", 32'(word_valid), 32'd1);
    check_eq("bp_first_buf", 32'(dct_buffer), 32'h15555555);
    send_atoms(15, 2'b10);
    send_atoms(15, 2'b11);
    check_eq("bp_held_buf", 32'(dct_buffer), 32'h15555555);
    check_eq("bp_held_cnt", 32'(dct_count), 32'd15);
`ifdef LAB4_CPU_DCT_DROP_CNT_EN
    check_eq("bp_drops", 32'(dct_drop_count), 32'd15);
`endif
    word_ready = 1'b1;
    step();
    check_eq("bp_second_valid", 32'(word_valid), 32'd1);
    check_eq("bp_second_buf", 32'(dct_buffer), 32'h2AAAAAAA);
    step();
    check_eq("bp_drained", 32'(word_valid), 32'd0);

    // ---- full fill + busy slot, then ready with atom 3
    apply_reset();
    send_atoms(15, 2'b00);
    send_atoms(15, 2'b10);
    word_ready = 1'b1;
    atom_valid = 1'b1;
    atom       = 2'b11;
    step();
    atom_valid = 1'b0;
    check_eq("mv_valid", 32'(word_valid), 32'd1);
    check_eq("mv_buf", 32'(dct_buffer), 32'h2AAAAAAA);
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    check_eq("mv_accept", 32'(word_valid), 32'd0);
    step();
    check_eq("mv_flush_valid", 32'(word_valid), 32'd1);
    check_eq("mv_flush_buf", 32'(dct_buffer), 32'h3);
    check_eq("mv_flush_cnt", 32'(dct_count), 32'd1);
`ifdef LAB4_CPU_DCT_DROP_CNT_EN
    check_eq("mv_no_drop", 32'(dct_drop_count), 32'd0);
`endif
    step();
    check_eq("mv_ended_early", 32'(test_has_ended), 32'd0);
    step();
    check_eq("mv_ended", 32'(test_has_ended), 32'd1);

    // ---- 5 atoms then test_ending: partial flush
    apply_reset();
    send_atoms(4, 2'b11);
    atom_valid  = 1'b1;
    atom        = 2'b11;
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    check_eq("fl_not_yet", 32'(word_valid), 32'd0);
    step();
    check_eq("fl_valid", 32'(word_valid), 32'd1);
    check_eq("fl_buf", 32'(dct_buffer), 32'h3FF);
    check_eq("fl_cnt", 32'(dct_count), 32'd5);
    step();
    step();
    step();
    check_eq("fl_stable_buf", 32'(dct_buffer), 32'h3FF);
    check_eq("fl_stable_cnt", 32'(dct_count), 32'd5);
    check_eq("fl_not_ended", 32'(test_has_ended), 32'd0);
`ifdef LAB4_CPU_DCT_DROP_CNT_EN
    check_eq("fl_no_drop", 32'(dct_drop_count), 32'd0);
`endif
    word_ready = 1'b1;
    step();
    check_eq("fl_accept", 32'(word_valid), 32'd0);
    check_eq("fl_ended_early", 32'(test_has_ended), 32'd0);
    step();
    check_eq("fl_ended", 32'(test_has_ended), 32'd1);
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    step();
    step();
    atom_valid = 1'b0;
    check_eq("fl_ignored_valid", 32'(word_valid), 32'd0);
    check_eq("fl_sticky", 32'(test_has_ended), 32'd1);

    // ---- test_ending with everything empty
    apply_reset();
    word_ready  = 1'b1;
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    check_eq("em_ended", 32'(test_has_ended), 32'd1);
    check_eq("em_valid", 32'(word_valid), 32'd0);
    send_atoms(16, 2'b01);
    check_eq("em_valid_after", 32'(word_valid), 32'd0);

    // ---- reset while a word is held and fill is partial
    apply_reset();
    send_atoms(15, 2'b01);
    send_atoms(7, 2'b11);
    check_eq("rw_held", 32'(word_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rw_valid0", 32'(word_valid), 32'd0);
    check_eq("rw_buf0", 32'(dct_buffer), 32'd0);
    check_eq("rw_cnt0", 32'(dct_count), 32'd0);
    step();
    reset_n    = 1'b1;
    word_ready = 1'b1;
    #2;
    send_atoms(15, 2'b10);
    check_eq("rw_clean_valid", 32'(word_valid), 32'd1);
    check_eq("rw_clean_buf", 32'(dct_buffer), 32'h2AAAAAAA);
    check_eq("rw_clean_cnt", 32'(dct_count), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
